// File: rtl/solver.sv
`default_nettype none
// ============================================================================
//  Module      : solver
//  Description : Nonogram line-elimination engine. It filters a stream of
//                per-line option words against the known board, re-queues the
//                consistent ones and folds them into the known/assigned maps.
//                Optional macro SOLVER_NEW_AMNT_EN adds the new_options_amnt
//                per-line survivor-count output.
//  Revision    : 1.0 - initial release
// ============================================================================
module solver #(
    parameter int SIZE = 11
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        started,
    input  logic [15:0]                 option,
    input  logic [3:0]                  num_rows,
    input  logic [3:0]                  num_cols,
    input  logic [2*SIZE-1:0][6:0]      old_options_amnt,
    output logic                        new_line,
    output logic [15:0]                 new_option,
    output logic                        put_back_to_FIFO,
    output logic [SIZE*SIZE-1:0]        assigned,
    output logic [SIZE*SIZE-1:0]        known,
`ifdef SOLVER_NEW_AMNT_EN
    output logic [2*SIZE-1:0][6:0]      new_options_amnt,
`endif
    output logic                        solved
);

    localparam int c_CELLS = SIZE * SIZE;
    localparam int c_LINES = 2 * SIZE;
    localparam int c_CW    = $clog2(c_CELLS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_INDEX  = 2'd1,
        S_OPTION = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [4:0]             r_idx;
    logic [6:0]             r_rem;
    logic [6:0]             r_surv;
    logic [SIZE-1:0]        r_and_acc;
    logic [SIZE-1:0]        r_or_acc;
    logic [c_CELLS-1:0]     r_known;
    logic [c_CELLS-1:0]     r_assigned;
    logic [15:0]            r_new_option;
    logic                   r_put_back;
    logic                   r_solved;

    logic [6:0]             w_idx_amnt;
    logic                   w_legal;
    logic                   w_is_row;
    logic [4:0]             w_col;
    logic [SIZE-1:0]        w_pos_valid;
    logic [SIZE-1:0]        w_pos_known;
    logic [SIZE-1:0]        w_pos_value;
    logic [c_CELLS-1:0]     w_fill_one;
    logic [c_CELLS-1:0]     w_fill_zero;
    logic [c_CELLS-1:0]     w_board;
    logic                   w_consistent;

    // Index words beyond the count table behave like an empty line.
    always_comb begin
        w_idx_amnt = '0;
        if (int'(option[4:0]) < c_LINES) begin
            w_idx_amnt = old_options_amnt[option[4:0]];
        end
    end

    assign w_legal  = ({1'b0, r_idx} < ({2'b00, num_rows} + {2'b00, num_cols}));
    assign w_is_row = ({1'b0, r_idx} < {2'b00, num_rows});
    assign w_col    = r_idx - {1'b0, num_rows};

    // Map each line position onto its board cell; out-of-board positions drop out.
    always_comb begin
        int              w_r;
        int              w_c;
        logic [c_CW-1:0] w_cell;
        w_r         = 0;
        w_c         = 0;
        w_cell      = '0;
        w_pos_valid = '0;
        w_pos_known = '0;
        w_pos_value = '0;
        w_fill_one  = '0;
        w_fill_zero = '0;
        for (int p = 0; p < SIZE; p++) begin
            w_r = w_is_row ? int'(r_idx) : p;
            w_c = w_is_row ? p : int'(w_col);
            if (w_legal && (w_r < int'(num_rows)) && (w_c < int'(num_cols)) &&
                (w_r < SIZE) && (w_c < SIZE)) begin
                w_cell         = c_CW'(w_r * SIZE + w_c);
                w_pos_valid[p] = 1'b1;
                w_pos_known[p] = r_known[w_cell];
                w_pos_value[p] = r_assigned[w_cell];
                if (r_and_acc[p]) begin
                    w_fill_one[w_cell] = 1'b1;
                end else if (!r_or_acc[p]) begin
                    w_fill_zero[w_cell] = 1'b1;
                end
            end
        end
    end

    assign w_consistent = w_legal &&
        ((w_pos_valid & w_pos_known & (option[SIZE-1:0] ^ w_pos_value)) == '0);

    for (genvar r = 0; r < SIZE; r++) begin : g_row
        for (genvar c = 0; c < SIZE; c++) begin : g_col
            assign w_board[r*SIZE+c] = (int'(num_rows) > r) && (int'(num_cols) > c);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_IDLE;
            S_INDEX:  if (w_idx_amnt != 7'd0) w_next = S_OPTION;
            S_OPTION: if (r_rem <= 7'd1) w_next = S_UPDATE;
            S_UPDATE: w_next = S_INDEX;
            default:  w_next = S_IDLE;
        endcase
        if (started) begin
            w_next = S_INDEX;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= '0;
            r_rem        <= '0;
            r_surv       <= '0;
            r_and_acc    <= '1;
            r_or_acc     <= '0;
            r_known      <= '0;
            r_assigned   <= '0;
            r_new_option <= '0;
            r_put_back   <= 1'b0;
            r_solved     <= 1'b0;
        end else begin
            r_put_back <= 1'b0;
            if (started) begin
                r_known    <= '0;
                r_assigned <= '0;
                r_solved   <= 1'b0;
            end else begin
                r_solved <= &(r_known | ~w_board);
                case (r_state)
                    S_INDEX: begin
                        r_idx     <= option[4:0];
                        r_rem     <= w_idx_amnt;
                        r_and_acc <= '1;
                        r_or_acc  <= '0;
                        r_surv    <= '0;
                    end
                    S_OPTION: begin
                        r_new_option <= option;
                        r_put_back   <= w_consistent;
                        r_rem        <= r_rem - 7'd1;
                        if (w_consistent) begin
                            r_and_acc <= r_and_acc & option[SIZE-1:0];
                            r_or_acc  <= r_or_acc | option[SIZE-1:0];
                            r_surv    <= r_surv + 7'd1;
                        end
                    end
                    S_UPDATE: begin
                        // A line with no survivors is a contradiction; leave the board alone.
                        if (r_surv != 7'd0) begin
                            r_known    <= r_known | w_fill_one | w_fill_zero;
                            r_assigned <= (r_assigned | w_fill_one) & ~w_fill_zero;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SOLVER_NEW_AMNT_EN
    logic [2*SIZE-1:0][6:0] r_new_amnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_new_amnt <= '0;
        end else if (!started) begin
            if ((r_state == S_INDEX) && (w_idx_amnt == 7'd0) && (int'(option[4:0]) < c_LINES)) begin
                r_new_amnt[option[4:0]] <= 7'd0;
            end else if ((r_state == S_UPDATE) && (int'(r_idx) < c_LINES)) begin
                r_new_amnt[r_idx] <= r_surv;
            end
        end
    end

    assign new_options_amnt = r_new_amnt;
`endif

    assign new_line         = (r_state == S_INDEX);
    assign new_option       = r_new_option;
    assign put_back_to_FIFO = r_put_back;
    assign known            = r_known;
    assign assigned         = r_assigned;
    assign solved           = r_solved;

endmodule

`default_nettype wire

// File: tb/tb_solver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_solver
//  Description : Directed and randomized checks of solver against a
//                cell-level nonogram board model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_solver;

    localparam int SIZE  = 11;
    localparam int LINES = 2 * SIZE;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   started;
    logic [15:0]            option;
    logic [3:0]             num_rows;
    logic [3:0]             num_cols;
    logic [LINES-1:0][6:0]  old_options_amnt;
    logic                   new_line;
    logic [15:0]            new_option;
    logic                   put_back_to_FIFO;
    logic [SIZE*SIZE-1:0]   assigned;
    logic [SIZE*SIZE-1:0]   known;
    logic                   solved;
`ifdef SOLVER_NEW_AMNT_EN
    logic [LINES-1:0][6:0]  new_options_amnt;
`endif

    solver #(.SIZE(SIZE)) dut (
        .clk              (clk),
        .rst              (rst),
        .started          (started),
        .option           (option),
        .num_rows         (num_rows),
        .num_cols         (num_cols),
        .old_options_amnt (old_options_amnt),
        .new_line         (new_line),
        .new_option       (new_option),
        .put_back_to_FIFO (put_back_to_FIFO),
        .assigned         (assigned),
        .known            (known),
`ifdef SOLVER_NEW_AMNT_EN
        .new_options_amnt (new_options_amnt),
`endif
        .solved           (solved)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          R;
    int          C;
    bit          mk  [SIZE][SIZE];
    bit          ma  [SIZE][SIZE];
    bit          sol [SIZE][SIZE];
    logic [15:0] q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int llen(input int idx);
        return (idx < R) ? C : R;
    endfunction

    function automatic int cell_r(input int idx, input int p);
        return (idx < R) ? idx : p;
    endfunction

    function automatic int cell_c(input int idx, input int p);
        return (idx < R) ? p : idx - R;
    endfunction

    function automatic bit consistent(input int idx, input logic [15:0] w);
        if (idx >= R + C) return 1'b0;
        for (int p = 0; p < llen(idx); p++) begin
            if (mk[cell_r(idx, p)][cell_c(idx, p)] && (w[p] != ma[cell_r(idx, p)][cell_c(idx, p)]))
                return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [127:0] model_vec(input bit want_assigned);
        logic [127:0] v = '0;
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                v[r*SIZE+c] = want_assigned ? ma[r][c] : mk[r][c];
        return v;
    endfunction

    function automatic bit model_solved();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                if (!mk[r][c]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [15:0] gen_option(input int idx);
        logic [15:0] w = 16'($urandom);
        if (idx < R + C) begin
            for (int p = 0; p < llen(idx); p++) begin
                if ($urandom_range(0, 3) != 0) w[p] = sol[cell_r(idx, p)][cell_c(idx, p)];
                if (mk[cell_r(idx, p)][cell_c(idx, p)] && ($urandom_range(0, 1) == 1))
                    w[p] = ma[cell_r(idx, p)][cell_c(idx, p)];
            end
        end
        return w;
    endfunction

    // Pulse started on a board of rows x cols and clear the model.
    task automatic start_board(input int rows, input int cols);
        R = rows;
        C = cols;
        num_rows = 4'(rows);
        num_cols = 4'(cols);
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++) begin
                mk[r][c]  = 1'b0;
                ma[r][c]  = 1'b0;
                sol[r][c] = 1'($urandom);
            end
        started = 1'b1;
        tick();
        started = 1'b0;
        check("start_known", known, '0);
        check("start_assigned", assigned, '0);
        check("start_solved", solved, 1'b0);
        check("start_new_line", new_line, 1'b1);
    endtask

    // Present one index word and the options in q, then check the board.
    task automatic do_line(input int idx);
        int          n = q.size();
        int          surv = 0;
        int          ones[SIZE];
        logic [15:0] w;
        bit          exp;
        foreach (ones[p]) ones[p] = 0;
        old_options_amnt[idx] = 7'(n);
        check("index_new_line", new_line, 1'b1);
        w = 16'($urandom);
        w[4:0] = 5'(idx);
        option = w;
        tick();
        check("solved", solved, model_solved());
        check("after_index_new_line", new_line, (n == 0) ? 1'b1 : 1'b0);
        if (n == 0) return;
        for (int k = 0; k < n; k++) begin
            option = q[k];
            exp = consistent(idx, q[k]);
            tick();
            check("put_back", put_back_to_FIFO, exp);
            check("new_option", new_option, q[k]);
            if (exp) begin
                surv++;
                for (int p = 0; p < llen(idx); p++) if (q[k][p]) ones[p]++;
            end
        end
        option = 16'($urandom);
        tick();
        check("put_back_idle", put_back_to_FIFO, 1'b0);
        if (surv > 0) begin
            for (int p = 0; p < llen(idx); p++) begin
                if (ones[p] == surv) begin
                    mk[cell_r(idx, p)][cell_c(idx, p)] = 1'b1;
                    ma[cell_r(idx, p)][cell_c(idx, p)] = 1'b1;
                end else if (ones[p] == 0) begin
                    mk[cell_r(idx, p)][cell_c(idx, p)] = 1'b1;
                    ma[cell_r(idx, p)][cell_c(idx, p)] = 1'b0;
                end
            end
        end
        check("known", known, model_vec(1'b0));
        check("assigned", assigned, model_vec(1'b1));
    endtask

    initial begin
        int idx;
        int nopt;
        rst = 1'b0;
        started = 1'b0;
        option = '0;
        num_rows = 4'd2;
        num_cols = 4'd3;
        old_options_amnt = '0;
        R = 2;
        C = 3;
        #2 rst = 1'b1;
        #2;
        check("rst_new_line", new_line, 1'b0);
        check("rst_known", known, '0);
        check("rst_assigned", assigned, '0);
        check("rst_solved", solved, 1'b0);
        check("rst_put_back", put_back_to_FIFO, 1'b0);
        check("rst_new_option", new_option, '0);
        tick();
        rst = 1'b0;
        tick();
        check("idle_new_line", new_line, 1'b0);

        // 2x3 board solved line by line
        start_board(2, 3);
        q = {}; q.push_back(16'h0007); do_line(0);
        check("row0_cells", known[2:0] & assigned[2:0], 3'b111);
        q = {}; q.push_back(16'h0000); do_line(1);
        q = {}; q.push_back(16'h0001); q.push_back(16'h0002); do_line(2);
        check("solved_held", solved, 1'b1);

        // asynchronous reset in the middle of an option burst
        old_options_amnt[0] = 7'd2;
        option = 16'h0000;
        tick();
        option = 16'h0007;
        tick();
        check("pre_rst_solved", solved, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_known", known, '0);
        check("mid_rst_solved", solved, 1'b0);
        check("mid_rst_put_back", put_back_to_FIFO, 1'b0);
        check("mid_rst_new_line", new_line, 1'b0);
        rst = 1'b0;
        tick();
        check("post_rst_idle", new_line, 1'b0);

        // partial determination, empty line, illegal index
        start_board(2, 3);
        q = {}; q.push_back(16'h0003); q.push_back(16'h0006); do_line(0);
        check("partial_known", known[2:0], 3'b010);
        q = {}; do_line(3);
        q = {}; q.push_back(16'h0005); do_line(7);

        // randomized boards
        for (int b = 0; b < 8; b++) begin
            start_board($urandom_range(1, SIZE), $urandom_range(1, SIZE));
            for (int l = 0; l < 40; l++) begin
                if (($urandom_range(0, 9) == 0) && (R + C < LINES))
                    idx = $urandom_range(R + C, LINES - 1);
                else
                    idx = $urandom_range(0, R + C - 1);
                nopt = $urandom_range(0, 5);
                q = {};
                for (int k = 0; k < nopt; k++) q.push_back(gen_option(idx));
                do_line(idx);
            end
            tick();
            check("final_solved", solved, model_solved());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/solver.md
Name: solver

Overview:
- Nonogram line-elimination engine. It consumes a stream of candidate line fillings (options) from an external option FIFO, one line at a time.
- For each option it decides whether to recycle it to the FIFO or drop it. It folds the surviving options into the board's known/assigned cell maps and flags when the whole board is determined.
- Sits between the option FIFO/controller and the board-state consumer.

Parameters:
- SIZE, 11: maximum board dimension. Board storage is SIZE*SIZE cells; up to 2*SIZE lines.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- started  in  1  one-cycle pulse; begins a solve
- option  in  16  line index word, or option word (bit p = cell p of the line)
- num_rows  in  4  board rows (1..SIZE)
- num_cols  in  4  board cols (1..SIZE)
- old_options_amnt  in  [2*SIZE-1:0][6:0]  option count currently queued for each line
- new_line  out  1  high while solver expects a line-index word
- new_option  out  16  echo of last evaluated option
- put_back_to_FIFO  out  1  one-cycle strobe: last option is consistent, re-queue it
- assigned  out  SIZE*SIZE  cell values; cell (r,c) at bit r*SIZE+c
- known  out  SIZE*SIZE  cell-determined flags, same indexing
- solved  out  1  every in-range cell known

Behaviour:
- Reset (async): state IDLE; known, assigned, new_option, put_back_to_FIFO, solved, new_line all 0.
- Line numbering:
  - Lines 0..num_rows-1 are rows; line num_rows+c is column c.
  - Row length is num_cols; column length is num_rows.
  - Option bit p maps to column p (row line) or row p (column line). Bits at or above the line length are ignored.
- States: IDLE, INDEX, OPTION, UPDATE.
- IDLE:
  - On started: clear known, assigned and solved; go to INDEX.
  - started in any other state also restarts this way.
- INDEX:
  - new_line=1. Each cycle, latch idx=option[4:0] and rem=old_options_amnt[idx].
  - Clear the accumulators: and_acc=all 1s, or_acc=0, surv=0.
  - If rem=0, stay in INDEX (next word is another index); else go to OPTION.
- OPTION (one word per cycle, no handshake; the producer must present a new word every cycle):
  - The option is consistent iff, for every in-range position p whose cell is known, option[p] equals assigned[cell].
  - Consistent: on the next edge put_back_to_FIFO=1 and new_option=option; and_acc&=option; or_acc|=option; surv++.
  - Inconsistent: put_back_to_FIFO=0 next cycle; new_option still updated.
  - rem decrements each cycle. After the word with rem=1, go to UPDATE.
- UPDATE (1 cycle; option bus ignored):
  - If surv>0, then for each in-range p:
    - and_acc[p]=1 sets known=1, assigned=1.
    - or_acc[p]=0 sets known=1, assigned=0.
  - If surv=0 (contradiction), there is no update.
  - Go to INDEX.
- Latency: option word to put_back_to_FIFO is 1 cycle. The last option word to the known/assigned update is 2 cycles.
- solved:
  - Registered and recomputed every cycle from known over r<num_rows, c<num_cols.
  - Stays high until started or rst.
- Illegal idx (>= num_rows+num_cols): options are still consumed and put_back_to_FIFO is forced 0. No board update.
- Known cells are never cleared except by started or rst. Cells outside the board stay 0.

Optional Feature:
- Macro: SOLVER_NEW_AMNT_EN.
- Defined: adds output new_options_amnt [2*SIZE-1:0][6:0], reset 0. In UPDATE (and in INDEX when rem=0), entry idx is written with surv, the count of consistent options re-queued. It is written even for illegal idx, where surv=0.
- Undefined: port absent; no other change.

Test Plan:
- 2x3 board, counts {1,1,2,2,2}; started; idx 0, opt 111 -> after 2 cycles, known bits 0,1,2 =1 and assigned bits 0,1,2 =1.
- Then idx 1, opt 000 -> known bits 11,12,13 =1, assigned=0; solved=1 one cycle after the update.
- Then idx 2 (col 0), opts 01 and 10 -> opt 10 is inconsistent (row1 is known 0), so put_back_to_FIFO is 1 for 01 and 0 for 10; no known change.
- Fresh solve; idx 0, count 2, opts 011 and 110 -> both put back; known bits 1 (=1); bits 0 and 2 unknown.
- Line with count 0 -> new_line stays high and the next word is taken as an index. rst asserted mid-OPTION -> immediate clear, solved=0.
- Illegal idx 7 on a 2x3 board with count 1 -> put_back_to_FIFO=0, board unchanged.
